// File: rtl/fp_mul_arbiter.sv
// Two-requester round-robin front end for a shared FP32 multiplier.
// One transaction in flight: grant in IDLE, wait MUL_LAT cycles in ISSUE, hold result in RESP.
module fp_mul_arbiter #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_p,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_p,
  input  logic        rsp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t      state_q;
  logic        prio_q;
  logic [2:0]  cnt_q;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic [31:0] rsp_p_q;
  logic        rsp_id_q;

  logic        gnt_valid;
  logic        gnt_id;

  // prio_q names the requester that wins when both are valid
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = prio_q;
      end else if (req0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  assign req0_ready = rst_n && gnt_valid && !gnt_id;
  assign req1_ready = rst_n && gnt_valid &&  gnt_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      cnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      rsp_p_q  <= '0;
      rsp_id_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            mul_a_q  <= gnt_id ? req1_a : req0_a;
            mul_b_q  <= gnt_id ? req1_b : req0_b;
            rsp_id_q <= gnt_id;
            prio_q   <= !gnt_id;
            cnt_q    <= 3'(MUL_LAT);
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q - 3'd1;
          // product is sampled in the last cycle of the multiplier latency window
          if (cnt_q == 3'd1) begin
            rsp_p_q <= mul_p;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: instances with MUL_LAT=1 and MUL_LAT=4, each fed by a
// delayed FP32 multiplier model, checked every cycle against a transaction-level model.
module tb_fp_mul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn[2], v0[2], v1[2], rdy0[2], rdy1[2], rv[2], rid[2], rr[2], bsy[2];
  logic [31:0] a0[2], b0[2], a1[2], b1[2], mula[2], mulb[2], mulp[2], rp[2];
  logic [31:0] pipe4[3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_rsp[2];
  int n_rsp0[2];
  logic        ids0[$];
  logic [31:0] ps0[$];

  // reference model state
  bit          m_inf[2];
  bit          m_rstd[2];
  int          m_rcyc[2];
  logic        m_id[2], m_prio[2];
  logic [31:0] m_ma[2], m_mb[2], m_p[2];

  fp_mul_arbiter #(.MUL_LAT(1)) dut1 (
    .clk(clk), .rst_n(rstn[0]),
    .req0_valid(v0[0]), .req0_a(a0[0]), .req0_b(b0[0]), .req0_ready(rdy0[0]),
    .req1_valid(v1[0]), .req1_a(a1[0]), .req1_b(b1[0]), .req1_ready(rdy1[0]),
    .mul_a(mula[0]), .mul_b(mulb[0]), .mul_p(mulp[0]),
    .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_p(rp[0]), .rsp_ready(rr[0]), .busy(bsy[0])
  );

  fp_mul_arbiter #(.MUL_LAT(4)) dut4 (
    .clk(clk), .rst_n(rstn[1]),
    .req0_valid(v0[1]), .req0_a(a0[1]), .req0_b(b0[1]), .req0_ready(rdy0[1]),
    .req1_valid(v1[1]), .req1_a(a1[1]), .req1_b(b1[1]), .req1_ready(rdy1[1]),
    .mul_a(mula[1]), .mul_b(mulb[1]), .mul_p(mulp[1]),
    .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_p(rp[1]), .rsp_ready(rr[1]), .busy(bsy[1])
  );

  // FP32 multiply, normal operands and zero, round to nearest even
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] pr;
    logic [23:0] m;
    logic        g, s;
    int          e;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    pr = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (pr[47]) begin
      m = {1'b0, pr[46:24]}; g = pr[23]; s = |pr[22:0]; e = e + 1;
    end else begin
      m = {1'b0, pr[45:23]}; g = pr[22]; s = |pr[21:0];
    end
    if (g && (s || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = '0; e = e + 1;
    end
    return {a[31] ^ b[31], 8'(e), m[22:0]};
  endfunction

  assign mulp[0] = fmul(mula[0], mulb[0]);
  assign mulp[1] = pipe4[2];
  initial begin
    pipe4[0] = '0; pipe4[1] = '0; pipe4[2] = '0;
  end
  always @(posedge clk) begin
    pipe4[0] <= fmul(mula[1], mulb[1]);
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
  end

  function automatic int lat(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int exp_gnt(int k);
    if (!rstn[k] || m_inf[k]) return -1;
    if (v0[k] && v1[k]) return int'(m_prio[k]);
    if (v0[k]) return 0;
    if (v1[k]) return 1;
    return -1;
  endfunction

  function automatic bit exp_rv(int k);
    return m_inf[k] && (cyc >= m_rcyc[k]);
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int g;
    for (int k = 0; k < 2; k++) begin
      g = exp_gnt(k);
      if (!rstn[k]) begin
        m_inf[k] <= 1'b0; m_prio[k] <= 1'b0; m_id[k] <= 1'b0; m_rstd[k] <= 1'b1;
        m_ma[k] <= '0; m_mb[k] <= '0; m_p[k] <= '0;
      end else begin
        m_rstd[k] <= 1'b0;
        if (g == 0) begin
          m_inf[k] <= 1'b1; m_rcyc[k] <= cyc + lat(k) + 1; m_id[k] <= 1'b0; m_prio[k] <= 1'b1;
          m_ma[k] <= a0[k]; m_mb[k] <= b0[k]; m_p[k] <= fmul(a0[k], b0[k]);
        end else if (g == 1) begin
          m_inf[k] <= 1'b1; m_rcyc[k] <= cyc + lat(k) + 1; m_id[k] <= 1'b1; m_prio[k] <= 1'b0;
          m_ma[k] <= a1[k]; m_mb[k] <= b1[k]; m_p[k] <= fmul(a1[k], b1[k]);
        end else if (exp_rv(k) && rr[k]) begin
          m_inf[k] <= 1'b0;
        end
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    int g;
    for (int k = 0; k < 2; k++) begin
      g = exp_gnt(k);
      chk("ready0", k, 32'(rdy0[k]), 32'(g == 0));
      chk("ready1", k, 32'(rdy1[k]), 32'(g == 1));
      chk("busy", k, 32'(bsy[k]), 32'(m_inf[k]));
      chk("rsp_valid", k, 32'(rv[k]), 32'(exp_rv(k)));
      chk("mul_a", k, mula[k], m_ma[k]);
      chk("mul_b", k, mulb[k], m_mb[k]);
      if (exp_rv(k) || m_rstd[k]) begin
        chk("rsp_id", k, 32'(rid[k]), 32'(m_id[k]));
        chk("rsp_p", k, rp[k], m_p[k]);
      end
      if (rv[k] && rr[k]) begin
        n_rsp[k]++;
        if (!rid[k]) n_rsp0[k]++;
        if (k == 0) begin
          ids0.push_back(rid[0]);
          ps0.push_back(rp[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int k);
    rstn[k] = 1'b0;
    step();
    rstn[k] = 1'b1;
  endtask

  task automatic wait_rdy(int k, bit which);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = which ? rdy1[k] : rdy0[k];
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL wait_ready dut%0d: got timeout expected ready%0d", k, which);
    end
  endtask

  task automatic wait_rv(int k);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = rv[k];
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL wait_rsp_valid dut%0d: got timeout expected rsp_valid", k);
    end
  endtask

  initial begin
    #50000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, n0, nr;
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; v0[k] = 1'b0; v1[k] = 1'b0; rr[k] = 1'b1;
      a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
      n_rsp[k] = 0; n_rsp0[k] = 0;
    end
    v0[0] = 1'b1;
    @(negedge clk);
    chk("reset_ready0", 0, 32'(rdy0[0]), 32'd0);
    chk("reset_busy", 0, 32'(bsy[0]), 32'd0);
    chk("reset_mul_a", 0, mula[0], 32'd0);
    chk("reset_rsp_p", 1, rp[1], 32'd0);
    step();
    rstn[0] = 1'b1; rstn[1] = 1'b1; v0[0] = 1'b0;

    // single request, MUL_LAT=1
    v0[0] = 1'b1; a0[0] = 32'h40000000; b0[0] = 32'h40400000;
    @(negedge clk);
    chk("t1_ready0", 0, 32'(rdy0[0]), 32'd1);
    step();
    v0[0] = 1'b0;
    @(negedge clk);
    chk("t1_mul_a", 0, mula[0], 32'h40000000);
    chk("t1_mul_b", 0, mulb[0], 32'h40400000);
    chk("t1_rsp_valid_early", 0, 32'(rv[0]), 32'd0);
    step();
    @(negedge clk);
    chk("t1_rsp_valid", 0, 32'(rv[0]), 32'd1);
    chk("t1_rsp_p", 0, rp[0], 32'h40C00000);
    chk("t1_rsp_id", 0, 32'(rid[0]), 32'd0);
    step();

    // both requesters valid continuously: round-robin
    do_reset(0);
    ids0.delete(); ps0.delete();
    v0[0] = 1'b1; a0[0] = 32'h3FC00000; b0[0] = 32'h3FC00000;
    v1[0] = 1'b1; a1[0] = 32'h40800000; b1[0] = 32'hC0000000;
    for (int i = 0; i < 14; i++) step();
    v0[0] = 1'b0; v1[0] = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t2_count", 0, 32'(ids0.size() >= 4), 32'd1);
    if (ids0.size() >= 4) begin
      chk("t2_id0", 0, 32'(ids0[0]), 32'd0);
      chk("t2_id1", 0, 32'(ids0[1]), 32'd1);
      chk("t2_id2", 0, 32'(ids0[2]), 32'd0);
      chk("t2_id3", 0, 32'(ids0[3]), 32'd1);
      chk("t2_p0", 0, ps0[0], 32'h40100000);
      chk("t2_p1", 0, ps0[1], 32'hC1000000);
    end

    // back-pressure for 10 cycles
    rr[0] = 1'b0;
    v1[0] = 1'b1; a1[0] = 32'hBE99999A; b1[0] = 32'h43FA2000;
    wait_rdy(0, 1'b1);
    step();
    v1[0] = 1'b0;
    wait_rv(0);
    v0[0] = 1'b1; v1[0] = 1'b1; a0[0] = 32'h3F800000; b0[0] = 32'h3F800000;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_rsp_valid", 0, 32'(rv[0]), 32'd1);
      chk("t3_rsp_id", 0, 32'(rid[0]), 32'd1);
      chk("t3_rsp_p", 0, rp[0], fmul(32'hBE99999A, 32'h43FA2000));
      chk("t3_ready0", 0, 32'(rdy0[0]), 32'd0);
      chk("t3_ready1", 0, 32'(rdy1[0]), 32'd0);
    end
    step();
    rr[0] = 1'b1; v0[0] = 1'b0; v1[0] = 1'b0;
    step();
    @(negedge clk);
    chk("t3_idle", 0, 32'(bsy[0]), 32'd0);
    step();

    // MUL_LAT=4 latency and product sampling point
    do_reset(1);
    v0[1] = 1'b1; a0[1] = 32'h40000000; b0[1] = 32'h40400000;
    wait_rdy(1, 1'b0);
    c = cyc;
    step();
    v0[1] = 1'b0;
    wait_rv(1);
    chk("t4_latency", 1, 32'(cyc - c), 32'd5);
    chk("t4_rsp_p", 1, rp[1], 32'h40C00000);
    step();
    v0[1] = 1'b1; a0[1] = 32'h3FC00000; b0[1] = 32'h3FC00000;
    wait_rdy(1, 1'b0);
    step();
    v0[1] = 1'b0;
    wait_rv(1);
    chk("t4_rsp_p2", 1, rp[1], 32'h40100000);
    step();

    // reset in the middle of ISSUE
    v0[1] = 1'b1; a0[1] = 32'h40800000; b0[1] = 32'hC0000000;
    wait_rdy(1, 1'b0);
    step();
    v0[1] = 1'b0;
    step();
    rstn[1] = 1'b0; v0[1] = 1'b1;
    @(negedge clk);
    chk("t5_rst_ready0", 1, 32'(rdy0[1]), 32'd0);
    step();
    rstn[1] = 1'b1; v0[1] = 1'b0;
    @(negedge clk);
    chk("t5_busy", 1, 32'(bsy[1]), 32'd0);
    chk("t5_rsp_valid", 1, 32'(rv[1]), 32'd0);
    chk("t5_mul_a", 1, mula[1], 32'd0);
    chk("t5_mul_b", 1, mulb[1], 32'd0);
    chk("t5_rsp_p", 1, rp[1], 32'd0);
    chk("t5_rsp_id", 1, 32'(rid[1]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      chk("t5_no_rsp", 1, 32'(rv[1]), 32'd0);
    end
    step();
    v0[1] = 1'b1; a0[1] = 32'h40000000; b0[1] = 32'h40400000;
    v1[1] = 1'b1; a1[1] = 32'h40800000; b1[1] = 32'hC0000000;
    @(negedge clk);
    chk("t5_ptr_ready0", 1, 32'(rdy0[1]), 32'd1);
    chk("t5_ptr_ready1", 1, 32'(rdy1[1]), 32'd0);
    step();
    v0[1] = 1'b0; v1[1] = 1'b0;
    wait_rv(1);
    chk("t5_rsp_id2", 1, 32'(rid[1]), 32'd0);
    chk("t5_rsp_p2", 1, rp[1], 32'h40C00000);
    step();

    // req0 pulsed while busy must be forgotten
    rr[0] = 1'b0;
    v1[0] = 1'b1; a1[0] = 32'h40400000; b1[0] = 32'h40400000;
    wait_rdy(0, 1'b1);
    step();
    v1[0] = 1'b0;
    n0 = n_rsp0[0]; nr = n_rsp[0];
    step();
    v0[0] = 1'b1; a0[0] = 32'h40000000; b0[0] = 32'h40000000;
    step();
    step();
    v0[0] = 1'b0;
    step();
    rr[0] = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("t6_no_id0_rsp", 0, 32'(n_rsp0[0] - n0), 32'd0);
    chk("t6_one_rsp", 0, 32'(n_rsp[0] - nr), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 1, legal range 1..4: cycles the shared combinational/pipelined FP32 multiplier needs between operand drive and product sampling.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_a, req0_b  input  32 each  requester 0 IEEE-754 single-precision operands.
REQ-006 req0_ready  output  1  block accepts requester 0 this cycle.
REQ-007 req1_valid  input  1; req1_a, req1_b  input  32 each; req1_ready  output  1; identical meaning for requester 1.
REQ-008 mul_a, mul_b  output  32 each  operands driven to the shared multiplier.
REQ-009 mul_p  input  32  product returned by the shared multiplier.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_id  output  1  requester that owns the result (0 or 1).
REQ-012 rsp_p  output  32  captured product.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RESP; exactly one transaction in flight.
REQ-016 In IDLE, reqN_ready SHALL be combinationally high only for the granted requester; both readies SHALL be low in ISSUE and RESP.
REQ-017 Grant in IDLE: only one valid -> that one; both valid -> the requester not granted last (round-robin pointer); neither -> no grant.
REQ-018 Round-robin pointer SHALL update only on an accepted handshake (valid && ready).
REQ-019 On handshake, the block SHALL register the granted operands into mul_a/mul_b, record rsp_id, load a latency counter with MUL_LAT, and enter ISSUE.
REQ-020 In ISSUE, the counter SHALL decrement each cycle; in the cycle it reads 1, the edge SHALL capture mul_p into rsp_p and enter RESP.
REQ-021 rsp_valid SHALL be high exactly in RESP, first asserted MUL_LAT+1 cycles after the handshake cycle.
REQ-022 rsp_p and rsp_id SHALL stay stable while rsp_valid is high and rsp_ready is low (back-pressure of unbounded length).
REQ-023 rsp_valid && rsp_ready SHALL return FSM to IDLE next edge; a new request SHALL be grantable in that IDLE cycle (throughput: one result per MUL_LAT+2 cycles minimum).
REQ-024 mul_a/mul_b SHALL hold their last values outside ISSUE; the block SHALL NOT modify operand or product bits (no rounding, no special-case handling).
REQ-025 Requester inputs SHALL be ignored when its ready is low; a request whose valid drops before grant SHALL be forgotten.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 With rst_n low at a rising edge: state=IDLE, pointer favours requester 0, counter=0, mul_a=mul_b=0, rsp_p=0, rsp_id=0, rsp_valid=0, busy=0, both readies low for that cycle.
REQ-028 Reset during ISSUE or RESP SHALL abort the transaction; no rsp_valid pulse for it after reset release.

Verification (bench models the multiplier as a MUL_LAT-deep delay of a correct FP32 product)
REQ-029 MUL_LAT=1, req0 only, a=0x40000000, b=0x40400000 -> req0_ready high in handshake cycle, mul_a/mul_b equal operands next cycle, rsp_valid two cycles after handshake with rsp_p=0x40C00000, rsp_id=0.
REQ-030 Both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; four results with rsp_id 0,1,0,1; no starvation.
REQ-031 req1 a=0xBE99999A, b=0x43FA2000, rsp_ready held low 10 cycles -> rsp_valid, rsp_id=1, rsp_p stable all 10 cycles; both readies low; IDLE the cycle after rsp_ready rises.
REQ-032 MUL_LAT=4 -> rsp_valid asserted exactly 5 cycles after handshake; rsp_p equals product sampled in the last ISSUE cycle, not earlier mul_p values.
REQ-033 rst_n low for one edge during ISSUE -> all outputs at REQ-027 values, no response emitted, next request served normally with pointer favouring requester 0.
REQ-034 req0_valid pulsed while busy, then dropped -> never accepted, no response with rsp_id=0 produced.
